// File: rtl/tile_judge.sv
// Game-rule stage for piano tiles: lane hit/miss judging, two-digit BCD score
// and the IDLE/PLAY/OVER state machine, evaluated once per key event or frame.
module tile_judge #(
    parameter int          HIT_LINE  = 400,
    parameter int          SCREEN_H  = 480,
    parameter logic [7:0]  KEY_L0    = 8'h04,
    parameter logic [7:0]  KEY_L1    = 8'h16,
    parameter logic [7:0]  KEY_L2    = 8'h07,
    parameter logic [7:0]  KEY_L3    = 8'h09,
    parameter logic [7:0]  KEY_START = 8'h2C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [7:0] keycode,
    input  logic [9:0] tile_y0,
    input  logic [9:0] tile_y1,
    input  logic [9:0] tile_y2,
    input  logic [9:0] tile_y3,
    input  logic [9:0] tile_size,
    output logic       start_game,
    output logic       game_over,
    output logic [3:0] tens_digit,
    output logic [3:0] ones_digit,
    output logic [3:0] clear_lane
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_PLAY = 2'd1;
    localparam logic [1:0]  S_OVER = 2'd2;
    localparam logic [10:0] LP_HIT = 11'(HIT_LINE);
    localparam logic [9:0]  LP_SCR = 10'(SCREEN_H);

    logic [1:0] r_state;
    logic       r_vs_s1, r_vs_s2, r_vs_d;
    logic [7:0] r_key_q;
    logic [3:0] r_hit;
    logic [3:0] r_tens, r_ones;
    logic [3:0] r_clear;
    logic       r_start, r_over;
    logic [9:0] r_prev [4];

    logic [9:0] w_y [4];
    logic [7:0] w_lane_key [4];
    logic       w_press, w_tick, w_over;
    logic [3:0] w_hittable;
    logic [1:0] w_nstate;
    logic [3:0] w_nhit, w_nclear, w_ntens, w_nones;
    logic [7:0] w_inc;

    // Score increment saturating at 99, ones digit carrying into tens.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd9 && o == 4'd9) return {t, o};
        if (o == 4'd9)              return {t + 4'd1, 4'd0};
        return {t, o + 4'd1};
    endfunction

    assign w_y[0] = tile_y0;
    assign w_y[1] = tile_y1;
    assign w_y[2] = tile_y2;
    assign w_y[3] = tile_y3;
    assign w_lane_key[0] = KEY_L0;
    assign w_lane_key[1] = KEY_L1;
    assign w_lane_key[2] = KEY_L2;
    assign w_lane_key[3] = KEY_L3;

    assign w_press = (keycode != r_key_q) && (keycode != 8'd0);
    assign w_tick  = r_vs_s2 & ~r_vs_d;
    assign w_inc   = bcd_inc(r_tens, r_ones);

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_hittable[n] = (({1'b0, w_y[n]} + {1'b0, tile_size}) >= LP_HIT) && (w_y[n] < LP_SCR);
        end
    end

    // Key event is judged before the frame check; either can end the game.
    always_comb begin
        w_nstate = r_state;
        w_ntens  = r_tens;
        w_nones  = r_ones;
        w_nhit   = r_hit;
        w_nclear = 4'b0000;
        w_over   = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_press && keycode == KEY_START) begin
                    w_nstate = S_PLAY;
                    w_ntens  = 4'd0;
                    w_nones  = 4'd0;
                    w_nhit   = 4'b0000;
                end
            end
            S_PLAY: begin
                if (w_press) begin
                    for (int n = 0; n < 4; n++) begin
                        if (keycode == w_lane_key[n]) begin
                            if (w_hittable[n] && !r_hit[n]) begin
                                w_nhit[n]   = 1'b1;
                                w_nclear[n] = 1'b1;
                                w_ntens     = w_inc[7:4];
                                w_nones     = w_inc[3:0];
                            end else begin
                                w_over = 1'b1;
                            end
                        end
                    end
                end
                if (w_tick) begin
                    for (int n = 0; n < 4; n++) begin
                        if (w_y[n] >= LP_SCR && !r_hit[n]) w_over = 1'b1;
                        if (w_y[n] < r_prev[n])             w_nhit[n] = 1'b0;
                    end
                end
                if (w_over) w_nstate = S_OVER;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_vs_d  <= 1'b0;
            r_key_q <= 8'd0;
            r_hit   <= 4'b0000;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_clear <= 4'b0000;
            r_start <= 1'b0;
            r_over  <= 1'b0;
            for (int n = 0; n < 4; n++) r_prev[n] <= 10'd0;
        end else begin
            r_vs_s1 <= vsync;
            r_vs_s2 <= r_vs_s1;
            r_vs_d  <= r_vs_s2;
            r_key_q <= keycode;
            r_state <= w_nstate;
            r_hit   <= w_nhit;
            r_tens  <= w_ntens;
            r_ones  <= w_nones;
            r_clear <= w_nclear;
            r_start <= (w_nstate == S_PLAY);
            r_over  <= (w_nstate == S_OVER);
            if (w_tick) begin
                for (int n = 0; n < 4; n++) r_prev[n] <= w_y[n];
            end
        end
    end

    assign start_game = r_start;
    assign game_over  = r_over;
    assign tens_digit = r_tens;
    assign ones_digit = r_ones;
    assign clear_lane = r_clear;

endmodule

// File: tb/tb_tile_judge.sv
// Directed bench for tile_judge: start, hits, BCD carry, saturation, misses and async reset.
module tb_tile_judge;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] keycode = 8'd0;
    logic [9:0] tile_y0 = 10'd0, tile_y1 = 10'd0, tile_y2 = 10'd0, tile_y3 = 10'd0;
    logic [9:0] tile_size = 10'd40;
    logic       start_game, game_over;
    logic [3:0] tens_digit, ones_digit, clear_lane;

    int n_cmp = 0;
    int n_bad = 0;
    int sc = 0;

    tile_judge dut (
        .clk(clk), .reset(reset), .vsync(vsync), .keycode(keycode),
        .tile_y0(tile_y0), .tile_y1(tile_y1), .tile_y2(tile_y2), .tile_y3(tile_y3),
        .tile_size(tile_size), .start_game(start_game), .game_over(game_over),
        .tens_digit(tens_digit), .ones_digit(ones_digit), .clear_lane(clear_lane)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane_code(input int n);
        case (n)
            0: return 8'h04;
            1: return 8'h16;
            2: return 8'h07;
            default: return 8'h09;
        endcase
    endfunction

    task automatic check_score(input string tag);
        check_eq({tag, "_tens"}, 32'(tens_digit), 32'(sc / 10));
        check_eq({tag, "_ones"}, 32'(ones_digit), 32'(sc % 10));
    endtask

    task automatic hit_lane(input int n);
        keycode = lane_code(n);
        step();
        if (sc < 99) sc++;
        check_eq("hit_clear", 32'(clear_lane), 32'(1) << n);
        check_score("hit");
        check_eq("hit_play", 32'(start_game), 32'd1);
        keycode = 8'd0;
        step();
        check_eq("clear_one_cycle", 32'(clear_lane), 32'd0);
    endtask

    task automatic frame(input logic [9:0] y);
        tile_y0 = y; tile_y1 = y; tile_y2 = y; tile_y3 = y;
        step();
        vsync = 1'b1;
        repeat (4) step();
        vsync = 1'b0;
        repeat (2) step();
    endtask

    task automatic restart();
        keycode = 8'd0;
        step();
        keycode = 8'h2C;
        step();
        sc = 0;
        check_eq("restart_play", 32'(start_game), 32'd1);
        check_eq("restart_over", 32'(game_over), 32'd0);
        check_score("restart");
        keycode = 8'd0;
        step();
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_eq("rst_start", 32'(start_game), 32'd0);
        check_eq("rst_over", 32'(game_over), 32'd0);
        check_eq("rst_clear", 32'(clear_lane), 32'd0);
        check_score("rst");

        // Start key held three cycles: one transition only
        keycode = 8'h2C;
        step();
        check_eq("start_play", 32'(start_game), 32'd1);
        check_score("start");
        repeat (2) step();
        check_eq("start_held", 32'(start_game), 32'd1);
        check_eq("start_held_over", 32'(game_over), 32'd0);
        keycode = 8'h2C;
        keycode = 8'd0;
        step();

        // Lane 1 hit, then a re-press of the same tile ends the game
        tile_y1 = 10'd380;
        hit_lane(1);
        keycode = 8'h16;
        step();
        check_eq("repress_over", 32'(game_over), 32'd1);
        check_eq("repress_start", 32'(start_game), 32'd0);
        check_eq("repress_clear", 32'(clear_lane), 32'd0);
        check_score("repress");

        // Run score through the BCD carry up to saturation
        restart();
        keycode = 8'h2C;
        step();
        check_eq("start_ignored", 32'(start_game), 32'd1);
        keycode = 8'd0;
        step();
        frame(10'd380);
        while (sc < 99) begin
            for (int n = 0; n < 4; n++) hit_lane(n);
            frame(10'd0);
            frame(10'd380);
        end
        for (int n = 0; n < 4; n++) hit_lane(n);
        check_eq("sat_tens", 32'(tens_digit), 32'd9);
        check_eq("sat_ones", 32'(ones_digit), 32'd9);

        // Missed tile in lane 3 detected on the next frame
        frame(10'd0);
        tile_y3 = 10'd480;
        step();
        vsync = 1'b1;
        begin
            int k;
            k = 0;
            while (k < 4 && !game_over) begin
                step();
                k++;
            end
        end
        check_eq("miss_over", 32'(game_over), 32'd1);
        check_eq("miss_start", 32'(start_game), 32'd0);
        check_score("miss");
        vsync = 1'b0;
        tile_y3 = 10'd0;
        step();

        // Early press: tile far above the hit line
        restart();
        tile_y0 = 10'd100;
        keycode = 8'h04;
        step();
        check_eq("early_over", 32'(game_over), 32'd1);
        check_eq("early_clear", 32'(clear_lane), 32'd0);
        check_score("early");

        // Asynchronous reset mid-game
        restart();
        tile_y0 = 10'd0;
        tile_y1 = 10'd380;
        hit_lane(1);
        vsync = 1'b1;
        step();
        reset = 1'b1;
        #1;
        check_eq("arst_start", 32'(start_game), 32'd0);
        check_eq("arst_over", 32'(game_over), 32'd0);
        check_eq("arst_tens", 32'(tens_digit), 32'd0);
        check_eq("arst_ones", 32'(ones_digit), 32'd0);
        check_eq("arst_clear", 32'(clear_lane), 32'd0);
        repeat (2) step();
        reset = 1'b0;
        vsync = 1'b0;
        step();
        restart();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
